// File: rtl/tpu_pkg.sv
// Shared constants, range helpers and flag struct for the systolic-array PEs.
package tpu_pkg;
  localparam int ACT_W_DEF  = 8;
  localparam int W_W_DEF    = 8;
  localparam int PSUM_W_DEF = 16;

  typedef struct packed {
    logic sat;
    logic swap_err;
  } pe_flags_t;

  // Bit patterns of the two's-complement extremes; truncate to the target width.
  function automatic logic [63:0] smax_of(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] smin_of(input int w);
    return 64'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/pe_mac.sv
// Combinational multiply-accumulate: extend, add at PSUM_W+1 bits, then clamp or wrap.
module pe_mac
  import tpu_pkg::*;
#(
  parameter int ACT_W    = ACT_W_DEF,
  parameter int W_W      = W_W_DEF,
  parameter int PSUM_W   = PSUM_W_DEF,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic [ACT_W-1:0]  act,
  input  logic [W_W-1:0]    weight,
  input  logic [PSUM_W-1:0] psum,
  output logic [PSUM_W-1:0] sum,
  output logic              sat
);
  localparam int P = ACT_W + W_W;
  localparam int E = PSUM_W + 1;
  localparam logic [PSUM_W-1:0] S_MAX = PSUM_W'(smax_of(PSUM_W));
  localparam logic [PSUM_W-1:0] S_MIN = PSUM_W'(smin_of(PSUM_W));

  if (PSUM_W < ACT_W + W_W) begin : g_bad_psum_w
    $error("pe_mac: PSUM_W must be at least ACT_W+W_W");
  end

  logic [P-1:0] act_x;
  logic [P-1:0] w_x;
  logic [P-1:0] prod;
  logic [E-1:0] prod_x;
  logic [E-1:0] psum_x;
  logic [E-1:0] sum_x;

  always_comb begin
    if (SIGNED != 0) begin
      act_x  = {{W_W{act[ACT_W-1]}}, act};
      w_x    = {{ACT_W{weight[W_W-1]}}, weight};
    end else begin
      act_x  = {{W_W{1'b0}}, act};
      w_x    = {{ACT_W{1'b0}}, weight};
    end
    prod = act_x * w_x;
    if (SIGNED != 0) begin
      prod_x = {{(E-P){prod[P-1]}}, prod};
      psum_x = {psum[PSUM_W-1], psum};
    end else begin
      prod_x = {{(E-P){1'b0}}, prod};
      psum_x = {1'b0, psum};
    end
    sum_x = psum_x + prod_x;
    sum   = sum_x[PSUM_W-1:0];
    sat   = 1'b0;
    // The extra top bit tells us whether the true sum left the PSUM_W range.
    if (SATURATE != 0) begin
      if (SIGNED != 0) begin
        if (sum_x[E-1] != sum_x[E-2]) begin
          sat = 1'b1;
          sum = sum_x[E-1] ? S_MIN : S_MAX;
        end
      end else if (sum_x[E-1]) begin
        sat = 1'b1;
        sum = '1;
      end
    end
  end
endmodule

// File: rtl/pe_dbuf.sv
// Systolic PE with a shadow weight filled over the weight chain while the active weight computes.
module pe_dbuf
  import tpu_pkg::*;
#(
  parameter int ACT_W    = ACT_W_DEF,
  parameter int W_W      = W_W_DEF,
  parameter int PSUM_W   = PSUM_W_DEF,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [ACT_W-1:0]  in_act,
  input  logic              in_act_valid,
  input  logic [PSUM_W-1:0] in_psum,
  input  logic [W_W-1:0]    in_wdata,
  input  logic              in_wvalid,
  input  logic              w_capture,
  input  logic              w_swap,
  output logic [ACT_W-1:0]  out_act,
  output logic              out_act_valid,
  output logic [PSUM_W-1:0] out_psum,
  output logic              out_psum_valid,
  output logic [W_W-1:0]    out_wdata,
  output logic              out_wvalid,
  output logic              shadow_full,
  output logic              sat_flag,
  output logic              swap_err
);
  logic [ACT_W-1:0]  act_q, act_d;
  logic              act_valid_q, act_valid_d;
  logic [PSUM_W-1:0] psum_q, psum_d;
  logic              psum_valid_q, psum_valid_d;
  logic [W_W-1:0]    wdata_q, wdata_d;
  logic              wvalid_q, wvalid_d;
  logic [W_W-1:0]    active_q, active_d;
  logic [W_W-1:0]    shadow_q, shadow_d;
  logic              shadow_full_q, shadow_full_d;
  pe_flags_t         flags_q, flags_d;

  logic [PSUM_W-1:0] mac_sum;
  logic              mac_sat;
  logic              do_capture;
  logic              do_swap;

  pe_mac #(
    .ACT_W(ACT_W), .W_W(W_W), .PSUM_W(PSUM_W), .SIGNED(SIGNED), .SATURATE(SATURATE)
  ) u_mac (
    .act(in_act), .weight(active_q), .psum(in_psum), .sum(mac_sum), .sat(mac_sat)
  );

  assign do_capture = in_wvalid & w_capture;
  assign do_swap    = w_swap & shadow_full_q;

  always_comb begin
    act_d         = act_q;
    act_valid_d   = act_valid_q;
    psum_d        = psum_q;
    psum_valid_d  = psum_valid_q;
    wdata_d       = wdata_q;
    wvalid_d      = wvalid_q;
    active_d      = active_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    flags_d       = flags_q;
    if (!stall) begin
      wdata_d      = in_wdata;
      wvalid_d     = in_wvalid;
      act_d        = in_act_valid ? in_act : '0;
      act_valid_d  = in_act_valid;
      psum_d       = in_psum_sel(in_act_valid, mac_sum, in_psum);
      psum_valid_d = in_act_valid;
      flags_d.sat      = in_act_valid & mac_sat;
      flags_d.swap_err = w_swap & ~shadow_full_q;
      // Swap reads the old shadow, so a same-cycle capture refills it without loss.
      if (do_swap) begin
        active_d      = shadow_q;
        shadow_full_d = 1'b0;
      end
      if (do_capture) begin
        shadow_d      = in_wdata;
        shadow_full_d = 1'b1;
      end
    end
  end

  function automatic logic [PSUM_W-1:0] in_psum_sel(input logic v, input logic [PSUM_W-1:0] a,
                                                    input logic [PSUM_W-1:0] b);
    return v ? a : b;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_q         <= '0;
      act_valid_q   <= 1'b0;
      psum_q        <= '0;
      psum_valid_q  <= 1'b0;
      wdata_q       <= '0;
      wvalid_q      <= 1'b0;
      active_q      <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      flags_q       <= '0;
    end else begin
      act_q         <= act_d;
      act_valid_q   <= act_valid_d;
      psum_q        <= psum_d;
      psum_valid_q  <= psum_valid_d;
      wdata_q       <= wdata_d;
      wvalid_q      <= wvalid_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      flags_q       <= flags_d;
    end
  end

  assign out_act        = act_q;
  assign out_act_valid  = act_valid_q;
  assign out_psum       = psum_q;
  assign out_psum_valid = psum_valid_q;
  assign out_wdata      = wdata_q;
  assign out_wvalid     = wvalid_q;
  assign shadow_full    = shadow_full_q;
  assign sat_flag       = flags_q.sat;
  assign swap_err       = flags_q.swap_err;
endmodule

// File: tb/tb_pe_dbuf.sv
// Directed bench: an unsigned wrapping PE and a signed saturating PE share one stimulus stream.
module tb_pe_dbuf;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [7:0]  in_act;
  logic        in_act_valid;
  logic [15:0] in_psum;
  logic [7:0]  in_wdata;
  logic        in_wvalid;
  logic        w_capture;
  logic        w_swap;

  logic [7:0]  u_act, s_act;
  logic        u_act_v, s_act_v;
  logic [15:0] u_psum, s_psum;
  logic        u_psum_v, s_psum_v;
  logic [7:0]  u_wdata, s_wdata;
  logic        u_wvalid, s_wvalid;
  logic        u_full, s_full;
  logic        u_sat, s_sat;
  logic        u_serr, s_serr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pe_dbuf #(.ACT_W(8), .W_W(8), .PSUM_W(16), .SIGNED(0), .SATURATE(0)) u_dut (
    .clk(clk), .reset(reset), .stall(stall),
    .in_act(in_act), .in_act_valid(in_act_valid), .in_psum(in_psum),
    .in_wdata(in_wdata), .in_wvalid(in_wvalid), .w_capture(w_capture), .w_swap(w_swap),
    .out_act(u_act), .out_act_valid(u_act_v), .out_psum(u_psum), .out_psum_valid(u_psum_v),
    .out_wdata(u_wdata), .out_wvalid(u_wvalid), .shadow_full(u_full),
    .sat_flag(u_sat), .swap_err(u_serr)
  );

  pe_dbuf #(.ACT_W(8), .W_W(8), .PSUM_W(16), .SIGNED(1), .SATURATE(1)) s_dut (
    .clk(clk), .reset(reset), .stall(stall),
    .in_act(in_act), .in_act_valid(in_act_valid), .in_psum(in_psum),
    .in_wdata(in_wdata), .in_wvalid(in_wvalid), .w_capture(w_capture), .w_swap(w_swap),
    .out_act(s_act), .out_act_valid(s_act_v), .out_psum(s_psum), .out_psum_valid(s_psum_v),
    .out_wdata(s_wdata), .out_wvalid(s_wvalid), .shadow_full(s_full),
    .sat_flag(s_sat), .swap_err(s_serr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [7:0] a, input logic [15:0] p,
                       input logic wv, input logic cap, input logic [7:0] wd, input logic sw);
    in_act_valid = av; in_act = a; in_psum = p;
    in_wvalid = wv; w_capture = cap; in_wdata = wd; w_swap = sw;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0;
    drive(0, 8'd0, 16'd0, 0, 0, 8'd0, 0);
    #2;
    check("rst_psum", u_psum, 0);
    check("rst_psum_v", u_psum_v, 0);
    check("rst_act_v", u_act_v, 0);
    check("rst_wvalid", u_wvalid, 0);
    check("rst_full", u_full, 0);
    @(negedge clk);
    reset = 1'b0;

    // Unsigned basics: capture 3, swap, MAC, bubble
    drive(0, 8'd0, 16'd0, 1, 1, 8'd3, 0); step();
    check("cap_full", u_full, 1);
    check("chain_wdata", u_wdata, 3);
    check("chain_wvalid", u_wvalid, 1);
    drive(0, 8'd0, 16'd0, 0, 0, 8'd0, 1); step();
    check("swap_empty_full", u_full, 0);
    check("swap_ok_err", u_serr, 0);
    drive(1, 8'd5, 16'd10, 0, 0, 8'd0, 0); step();
    check("mac_psum", u_psum, 25);
    check("mac_psum_v", u_psum_v, 1);
    check("mac_act", u_act, 5);
    check("mac_act_v", u_act_v, 1);
    drive(0, 8'd9, 16'd7, 0, 0, 8'd0, 0); step();
    check("bub_psum", u_psum, 7);
    check("bub_psum_v", u_psum_v, 0);
    check("bub_act", u_act, 0);

    // Overlap: active=2, capture 9 while streaming, swap at cycle k
    drive(0, 8'd0, 16'd0, 1, 1, 8'd2, 0); step();
    drive(0, 8'd0, 16'd0, 0, 0, 8'd0, 1); step();
    drive(1, 8'd4, 16'd0, 1, 1, 8'd9, 0); step();
    check("ovl_pre", u_psum, 8);
    check("ovl_full1", u_full, 1);
    drive(1, 8'd4, 16'd0, 0, 0, 8'd0, 1); step();
    check("ovl_k", u_psum, 8);
    check("ovl_full0", u_full, 0);
    drive(1, 8'd4, 16'd0, 0, 0, 8'd0, 0); step();
    check("ovl_k1", u_psum, 36);

    // Same-cycle capture+swap, then swap on empty shadow
    drive(1, 8'd1, 16'd0, 1, 1, 8'd6, 0); step();
    drive(1, 8'd1, 16'd0, 1, 1, 8'd7, 1); step();
    check("cs_old_active", u_psum, 9);
    check("cs_full", u_full, 1);
    drive(1, 8'd1, 16'd0, 0, 0, 8'd0, 0); step();
    check("cs_active6", u_psum, 6);
    drive(1, 8'd1, 16'd0, 0, 0, 8'd0, 1); step();
    check("cs_swap7_full", u_full, 0);
    drive(1, 8'd1, 16'd0, 0, 0, 8'd0, 1); step();
    check("empty_swap_err", u_serr, 1);
    check("empty_active7", u_psum, 7);
    drive(1, 8'd1, 16'd0, 0, 0, 8'd0, 0); step();
    check("empty_err_pulse", u_serr, 0);
    check("empty_unchanged", u_psum, 7);

    // Signed saturation high and low; unsigned wrap
    drive(0, 8'd0, 16'd0, 1, 1, 8'h80, 0); step();
    drive(0, 8'd0, 16'd0, 0, 0, 8'd0, 1); step();
    drive(1, 8'h80, 16'h7fff, 0, 0, 8'd0, 0); step();
    check("s_sat_hi", s_psum, 16'h7fff);
    check("s_sat_hi_flag", s_sat, 1);
    check("u_nosat_sum", u_psum, 49151);
    check("u_nosat_flag", u_sat, 0);
    drive(0, 8'd0, 16'd0, 1, 1, 8'd1, 0); step();
    check("s_flag_pulse", s_sat, 0);
    drive(0, 8'd0, 16'd0, 0, 0, 8'd0, 1); step();
    drive(1, 8'hff, 16'h8000, 0, 0, 8'd0, 0); step();
    check("s_sat_lo", s_psum, 16'h8000);
    check("s_sat_lo_flag", s_sat, 1);
    drive(0, 8'd0, 16'd0, 1, 1, 8'hff, 0); step();
    drive(0, 8'd0, 16'd0, 0, 0, 8'd0, 1); step();
    drive(1, 8'hff, 16'hffff, 0, 0, 8'd0, 0); step();
    check("u_wrap", u_psum, 65024);
    check("u_wrap_flag", u_sat, 0);
    check("s_neg_mac", s_psum, 0);
    check("s_neg_flag", s_sat, 0);

    // Stall with w_swap held
    drive(1, 8'd2, 16'd1, 1, 1, 8'd3, 0); step();
    check("pre_stall_psum", u_psum, 511);
    stall = 1'b1;
    drive(1, 8'd1, 16'd100, 0, 0, 8'd0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_psum", u_psum, 511);
      check("stall_act", u_act, 2);
      check("stall_full", u_full, 1);
    end
    stall = 1'b0; step();
    check("unstall_old_w", u_psum, 355);
    check("unstall_swap", u_full, 0);
    drive(1, 8'd1, 16'd100, 0, 0, 8'd0, 0); step();
    check("post_swap_w", u_psum, 103);

    // Asynchronous reset mid-stream
    #3 reset = 1'b1;
    #1;
    check("arst_psum", u_psum, 0);
    check("arst_act_v", u_act_v, 0);
    check("arst_psum_v", u_psum_v, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 8'd5, 16'd10, 0, 0, 8'd0, 0); step();
    check("cold_active0", u_psum, 10);
    drive(0, 8'd0, 16'd0, 0, 0, 8'd0, 1); step();
    check("cold_shadow_empty", u_serr, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
